sound_mmio: RTL
===============

Name: sound_mmio

Overview:
- CPU-write-side MMIO peripheral. It is the output counterpart of the existing read-only controller MMIO.
- Decodes processor stores to 0xFFFF_01xx. Queues tone commands in a small FIFO and plays each one as a square wave on the board audio pin.
- Sits beside the controller MMIO, RAM, and sprite/bullet RAMs on the processor data-memory bus, clocked by the 25 MHz system clock.
- Provides a readable status word so game code can poll queue state.

Parameters:
- FIFO_DEPTH, 4, number of queued tone commands (power of two, 2..16).
- TICK_DIV, 25000, clock cycles per duration unit (1 ms at 25 MHz).
- PAGE, 8'h01, value matched against address[15:8] inside the 0xFFFF_xxxx MMIO space.

Ports:
- clk  input  1  system clock (25 MHz domain).
- reset  input  1  synchronous, active-high reset.
- address  input  32  processor data address.
- wEn  input  1  processor store strobe.
- dataIn  input  32  processor store data.
- readEn  input  1  processor load strobe.
- readData  output  32  registered read data.
- audioOut  output  1  square-wave audio output.
- audioEn  output  1  amplifier shutdown-not (high while playing).

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high on `reset`.
- Select: `sel = (address[31:16]==16'hFFFF) && (address[15:8]==PAGE)`. Register offset = address[3:2]. Accesses outside `sel` are ignored and leave state unchanged.
- Offset 0 (CMD, write):
  - dataIn[15:0] = half-period in clk cycles (HP).
  - dataIn[31:16] = duration in TICK_DIV units (DUR).
  - A valid write pushes one entry into the FIFO.
- Offset 1 (STATUS, read):
  - bit0 busy (FSM not IDLE).
  - bit1 full.
  - bit2 empty.
  - bits[7:3] count.
  - bit8 overflow (sticky).
  - All other bits 0.
- Offset 2 (FLUSH, write): any data value triggers a flush.
- Offset 3: reads return 0; writes are ignored.
- Read latency is 1 cycle: readData is registered on a cycle with readEn && sel. readData holds its value otherwise. A STATUS read clears overflow in the same cycle it is sampled, so the returned value shows the pre-clear bit.
- Reset values:
  - readData=0, audioOut=0, audioEn=0.
  - FIFO empty, overflow=0, FSM=IDLE, all counters 0.
- FIFO:
  - Push when the CMD write is accepted. Pop when the FSM is in LOAD.
  - Simultaneous push and pop are both honoured; count is unchanged.
  - Push while full (and no same-cycle pop): entry is dropped and overflow is set to 1.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM:
  - IDLE → LOAD when FIFO is not empty.
  - LOAD (1 cycle): pop the head entry and latch HP and DUR.
    - If DUR==0: discard the entry and go to IDLE.
    - Otherwise: go to PLAY, with phase counter = 0, tick counter = 0, remaining = DUR.
  - PLAY:
    - If HP==0 (rest): audioOut=0.
    - If HP≠0: the phase counter runs 0..HP-1; on reaching HP-1, audioOut toggles and the phase counter returns to 0.
    - The tick counter runs 0..TICK_DIV-1. On wrap, remaining decrements.
    - When remaining reaches 0: audioOut=0, then go to LOAD if the FIFO is not empty, else IDLE. No idle gap cycle is inserted between back-to-back notes beyond the LOAD cycle.
- Outputs vs state: audioEn=1 exactly while FSM==PLAY and HP≠0. audioOut starts low at each note.
- Flush:
  - FIFO cleared, FSM→IDLE, audioOut=0, audioEn=0, all on the next edge. overflow is unchanged.
  - Flush has priority over a same-cycle CMD push (push dropped, overflow not set) and over a same-cycle LOAD.
- Reset mid-note: same as the reset values above, taking effect on the next edge.

Optional Feature:
- Macro: SOUND_MMIO_IRQ_EN.
- Defined:
  - Adds output port irqOut, 1 bit, reset 0.
  - irqOut pulses high for exactly one cycle when PLAY ends and the FIFO is empty (queue drained).
  - No pulse on flush or reset.
  - STATUS bit9 = irq-pending, sticky, cleared by a STATUS read.
- Undefined: no irqOut port; STATUS bit9 reads 0.

Decomposition:
- Shared package `sound_pkg`:
  - Register offsets (CMD=2'd0, STATUS=2'd1, FLUSH=2'd2).
  - FSM state encoding (IDLE, LOAD, PLAY).
  - Command field positions (HP_LSB/MSB, DUR_LSB/MSB).
  - The MMIO upper-half constant 16'hFFFF.
- One sub-module: `sound_fifo`, a synchronous FIFO with push, pop, flush, full, empty, and count, parameterised by DEPTH and WIDTH=32.

Test Plan:
- Reset, then read STATUS → readData=32'h0000_0004 (empty only) on the cycle after readEn. audioOut=0, audioEn=0.
- Write CMD 32'h0002_0003 (HP=3, DUR=2), with TICK_DIV=10 in the bench.
  - Expected: audioOut toggles every 3 cycles starting from the cycle after LOAD, for 20 PLAY cycles, then returns to 0.
  - audioEn is high for exactly those 20 cycles. Status then reads busy=0.
- Push 5 commands with FIFO_DEPTH=4 while the FSM is stalled on a long note.
  - Expected: 5th push dropped; STATUS count=4, full=1, overflow=1.
  - A second STATUS read then shows overflow=0.
- CMD with DUR=0 followed by CMD 32'h0001_0000 (rest).
  - Expected: the first entry is discarded after its single LOAD cycle.
  - The rest note holds audioOut=0 and audioEn=0 for TICK_DIV cycles with busy=1.
- FLUSH during PLAY with 2 entries queued, plus a same-cycle CMD write.
  - Expected: next cycle FSM=IDLE, count=0, audioOut=0, overflow unchanged; the pushed entry is absent.
- With SOUND_MMIO_IRQ_EN: play two back-to-back notes.
  - Expected: exactly one irqOut pulse, the cycle after the second note ends; none between the notes.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants for the sound MMIO peripheral: register map, FSM states,
// command field positions and the STATUS word layout.
package sound_pkg;

    localparam logic [1:0]  REG_CMD    = 2'd0;
    localparam logic [1:0]  REG_STATUS = 2'd1;
    localparam logic [1:0]  REG_FLUSH  = 2'd2;

    localparam logic [15:0] MMIO_HI    = 16'hFFFF;

    localparam int HP_LSB  = 0;
    localparam int HP_MSB  = 15;
    localparam int DUR_LSB = 16;
    localparam int DUR_MSB = 31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2
    } state_e;

    function automatic logic [31:0] pack_status(
        input logic       busy,
        input logic       full,
        input logic       empty,
        input logic [4:0] count,
        input logic       ovf,
        input logic       irq_pend
    );
        pack_status = {22'd0, irq_pend, ovf, count, empty, full, busy};
    endfunction

endpackage

// File: rtl/sound_fifo.sv
// Synchronous FIFO for queued tone commands; flush clears it in one edge.
// DEPTH must be a power of two so the pointers wrap naturally.
module sound_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    // A pop frees a slot in the same cycle, so push-while-full is honoured then.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/sound_mmio.sv
// Write-side MMIO tone generator: queued square-wave notes on audioOut.
// Build macro SOUND_MMIO_IRQ_EN adds irqOut and STATUS bit9 (irq pending).
//
// state | meaning
// IDLE  | nothing playing, waiting for a queued command
// LOAD  | pop head command, latch half-period and duration
// PLAY  | square wave (or rest) until the duration expires
module sound_mmio
    import sound_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter int         TICK_DIV   = 25000,
    parameter logic [7:0] PAGE       = 8'h01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        wEn,
    input  logic [31:0] dataIn,
    input  logic        readEn,
    output logic [31:0] readData,
    output logic        audioOut,
    output logic        audioEn
`ifdef SOUND_MMIO_IRQ_EN
    ,
    output logic        irqOut
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          sel, cmd_wr, flush, rd, status_rd;
    logic [1:0]    offset;
    logic          addr_unused;

    state_e        state_q;
    logic [15:0]   hp_q, phase_q, rem_q;
    logic [TW-1:0] tick_q;
    logic          audio_q, aen_q, ovf_q;
    logic [31:0]   rdata_q;

    logic [31:0]   head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push, pop, drop, note_end, irq_pend;
    logic [31:0]   status_w;

    assign sel         = (address[31:16] == MMIO_HI) && (address[15:8] == PAGE);
    assign offset      = address[3:2];
    assign addr_unused = ^{address[7:4], address[1:0]};
    assign cmd_wr      = sel && wEn && (offset == REG_CMD);
    assign flush       = sel && wEn && (offset == REG_FLUSH);
    assign rd          = sel && readEn;
    assign status_rd   = rd && (offset == REG_STATUS);

    assign pop      = (state_q == S_LOAD) && !flush;
    assign push     = cmd_wr && !flush;
    assign drop     = push && fifo_full && !pop;
    assign note_end = (state_q == S_PLAY) && (tick_q == TICK_LAST) && (rem_q == 16'd1) && !flush;

    sound_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (dataIn),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hp_q    <= '0;
            phase_q <= '0;
            rem_q   <= '0;
            tick_q  <= '0;
            audio_q <= 1'b0;
            aen_q   <= 1'b0;
        end else if (flush) begin
            state_q <= S_IDLE;
            audio_q <= 1'b0;
            aen_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    hp_q    <= head[HP_MSB:HP_LSB];
                    rem_q   <= head[DUR_MSB:DUR_LSB];
                    phase_q <= '0;
                    tick_q  <= '0;
                    audio_q <= 1'b0;
                    if (head[DUR_MSB:DUR_LSB] == 16'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q <= S_PLAY;
                        aen_q   <= (head[HP_MSB:HP_LSB] != 16'd0);
                    end
                end
                S_PLAY: begin
                    if (hp_q != 16'd0) begin
                        if (phase_q == hp_q - 16'd1) begin
                            phase_q <= '0;
                            audio_q <= ~audio_q;
                        end else begin
                            phase_q <= phase_q + 16'd1;
                        end
                    end
                    if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        rem_q  <= rem_q - 16'd1;
                    end else begin
                        tick_q <= tick_q + 1'b1;
                    end
                    // Last tick of the note: silence overrides any toggle above.
                    if (note_end) begin
                        audio_q <= 1'b0;
                        aen_q   <= 1'b0;
                        state_q <= fifo_empty ? S_IDLE : S_LOAD;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign status_w = pack_status(state_q != S_IDLE, fifo_full, fifo_empty,
                                  5'(fifo_count), ovf_q, irq_pend);

    // Overflow set wins over a same-cycle STATUS clear so no drop goes unseen.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (rd) rdata_q <= (offset == REG_STATUS) ? status_w : 32'd0;
            if (drop)           ovf_q <= 1'b1;
            else if (status_rd) ovf_q <= 1'b0;
        end
    end

`ifdef SOUND_MMIO_IRQ_EN
    logic irq_q, irq_pend_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q      <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            irq_q <= note_end && fifo_empty;
            if (note_end && fifo_empty) irq_pend_q <= 1'b1;
            else if (status_rd)         irq_pend_q <= 1'b0;
        end
    end

    assign irqOut   = irq_q;
    assign irq_pend = irq_pend_q;
`else
    assign irq_pend = 1'b0;
`endif

    assign readData = rdata_q;
    assign audioOut = audio_q;
    assign audioEn  = aen_q;

endmodule
